uart_tx_cfg: RTL and testbench
==============================

# uart_tx_cfg

Parametrised UART transmitter, the successor to `uart_tx`. It serialises words from a small internal FIFO onto `o_Tx_Serial`. Data width, parity mode, stop-bit count and FIFO depth are set at build time. It sits between the host write port and the pad, and allows back-to-back frames without host stalls.

## Interface
- `CLK_CY_PER_BIT`, 87: clock cycles per serial bit (≥2).
- `DATA_BITS`, 8: data bits per frame, 5..8.
- `PARITY_MODE`, 1: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: FIFO entries, power of two, ≥2.
- `i_clk`  in  1  system clock; all logic on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_Tx_Dv`  in  1  write strobe; one word accepted per cycle while `o_Tx_Ready`=1.
- `i_Tx_Byte`  in  DATA_BITS  word to transmit, sampled with `i_Tx_Dv`.
- `o_Tx_Ready`  out  1  FIFO not full (registered).
- `o_Tx_Active`  out  1  a frame is on the line.
- `o_Tx_Serial`  out  1  serial line, idle high.
- `o_Tx_Done`  out  1  one-cycle pulse at frame end.
- `o_Fifo_Count`  out  $clog2(FIFO_DEPTH)+1  words queued, excluding the word in flight.
- `o_Overflow`  out  1  one-cycle pulse when a write is dropped.

## Operation
- Reset values:
  - `o_Tx_Serial`=1, `o_Tx_Ready`=1.
  - `o_Tx_Active`, `o_Tx_Done`, `o_Overflow`, `o_Fifo_Count` = 0.
  - FSM goes to IDLE and the FIFO is emptied.
- Frame format: start(0), data LSB first, optional parity, then STOP_BITS high bits.
- Parity is computed on the popped word and registered at pop:
  - even: `^data`
  - odd: `~^data`
- FSM states: IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE: if FIFO is non-empty, pop, load the shift register, go to START.
  - START: lasts one bit period.
  - DATA: DATA_BITS periods; a bit index counts 0..DATA_BITS-1.
  - PARITY: skipped when PARITY_MODE=0.
  - STOP: STOP_BITS periods.
- A baud counter runs 0..CLK_CY_PER_BIT-1 and clears on every state or bit change.
- Frame end:
  - `o_Tx_Done` is asserted for exactly one cycle.
  - If the FIFO is non-empty, the next pop and start bit begin on the same edge: no idle gap, and `o_Tx_Active` stays 1.
  - Otherwise the FSM returns to IDLE with the line high.
- Write while `o_Tx_Ready`=0: the word is dropped, `o_Overflow` pulses, and the FIFO is unchanged. This holds even if a pop occurs in the same cycle.
- Simultaneous write and pop on a non-full FIFO: both take effect and the count is unchanged.
- Reset mid-frame aborts immediately. The line returns high asynchronously and the frame is not resumed.

## Timing
- Write at edge N into an empty FIFO with FSM idle:
  - pop at edge N+1.
  - `o_Tx_Serial`=0 and `o_Tx_Active`=1 from edge N+1.
- Frame length = CLK_CY_PER_BIT × (1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS) cycles, measured from the start-bit edge to the `o_Tx_Done` edge.
- `o_Tx_Done` is high during the final cycle of the last stop bit.
- `o_Tx_Active` falls on the following edge when no word is queued.
- `o_Tx_Ready` and `o_Fifo_Count` update on the edge after the write or pop.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `uart_pkg`:
  - parity-mode constants: PAR_NONE, PAR_EVEN, PAR_ODD.
  - FSM state encoding.
  - `CLK_CY_PER_BIT` derivation helper from clock and baud rate.
- One sub-module, `uart_tx_fifo`: synchronous FIFO with registered full, empty and count, and async active-low reset.
- The FSM, baud counter, bit index and shift register live in the top module.

## Test plan
- 10 MHz clock, CLK_CY_PER_BIT=87, 8-bit, even parity, 1 stop. Write 0xAA → line shows 0, 0,1,0,1,0,1,0,1, parity 0, 1. Each bit holds 87 cycles. `o_Tx_Done` pulses once, 957 cycles after the start edge.
- PARITY_MODE=2, DATA_BITS=7, STOP_BITS=2. Write 0x07 → parity bit 0, two stop bits, 957 cycles total.
- Write 0x55, 0x0F, 0xF0 on consecutive cycles → three frames with no idle gap between them. `o_Tx_Active` stays high throughout. Three `o_Tx_Done` pulses, 957 cycles apart.
- FIFO_DEPTH=4, while the line is busy: write 6 words in 6 cycles → 1 word in flight and 4 queued. `o_Tx_Ready` falls and the sixth write raises `o_Overflow` for one cycle. Exactly 5 frames are sent.
- Assert `i_rst_n`=0 in the middle of the DATA phase → line goes 1 immediately and all outputs take their reset values. No frame is sent after release until the next write.
- PARITY_MODE=0, DATA_BITS=5. Write 0x1F → frame of 7 bit periods (609 cycles) with no parity bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM encoding and baud divider helper.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Clock cycles per serial bit, rounded to nearest.
    function automatic int unsigned calc_clk_cy_per_bit(input int unsigned clk_hz,
                                                        input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered full/empty/count; writes while full are ignored.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             wr_c;
    logic             rd_c;

    // A write is refused on full even when a pop happens in the same cycle.
    assign wr_c    = wr_en_i && !full_q;
    assign rd_c    = rd_en_i && !empty_q;
    assign count_d = count_q + CW'(wr_c) - CW'(rd_c);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_c) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_c) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign count_o   = count_q;

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter fed by an internal FIFO; frames run back to back while words are queued.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_CY_PER_BIT = 87,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned PARITY_MODE    = 1,
    parameter int unsigned STOP_BITS      = 1,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_Tx_Dv,
    input  logic [DATA_BITS-1:0]        i_Tx_Byte,
    output logic                        o_Tx_Ready,
    output logic                        o_Tx_Active,
    output logic                        o_Tx_Serial,
    output logic                        o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
    output logic                        o_Overflow
);

    localparam int unsigned BW = $clog2(CLK_CY_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS);

    tx_state_e            state_q;
    logic [BW-1:0]        baud_q;
    logic [IW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 serial_q;
    logic                 active_q;
    logic                 done_q;
    logic                 ovf_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 pop_c;
    logic                 bit_end_c;
    logic                 last_stop_c;
    logic                 frame_end_c;
    logic                 done_c;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .wr_en_i   (i_Tx_Dv),
        .wr_data_i (i_Tx_Byte),
        .rd_en_i   (pop_c),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (o_Fifo_Count)
    );

    // Done is registered one cycle early so it is high during the last stop-bit cycle.
    assign bit_end_c   = (baud_q == BW'(CLK_CY_PER_BIT - 1));
    assign last_stop_c = (state_q == ST_STOP) && (bit_idx_q == IW'(STOP_BITS - 1));
    assign frame_end_c = last_stop_c && bit_end_c;
    assign done_c      = last_stop_c && (baud_q == BW'(CLK_CY_PER_BIT - 2));
    assign pop_c       = !fifo_empty && ((state_q == ST_IDLE) || frame_end_c);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= done_c;
            ovf_q  <= i_Tx_Dv && fifo_full;
            baud_q <= bit_end_c ? '0 : baud_q + BW'(1);
            if (pop_c) begin
                state_q  <= ST_START;
                baud_q   <= '0;
                shift_q  <= fifo_rd_data;
                par_q    <= (PARITY_MODE == PAR_ODD) ? ~^fifo_rd_data : ^fifo_rd_data;
                serial_q <= 1'b0;
                active_q <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE: baud_q <= '0;
                    ST_START: begin
                        if (bit_end_c) begin
                            state_q   <= ST_DATA;
                            bit_idx_q <= '0;
                            serial_q  <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end
                    ST_DATA: begin
                        if (bit_end_c) begin
                            if (bit_idx_q == IW'(DATA_BITS - 1)) begin
                                bit_idx_q <= '0;
                                if (PARITY_MODE != PAR_NONE) begin
                                    state_q  <= ST_PARITY;
                                    serial_q <= par_q;
                                end else begin
                                    state_q  <= ST_STOP;
                                    serial_q <= 1'b1;
                                end
                            end else begin
                                bit_idx_q <= bit_idx_q + IW'(1);
                                serial_q  <= shift_q[0];
                                shift_q   <= shift_q >> 1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (bit_end_c) begin
                            state_q  <= ST_STOP;
                            serial_q <= 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (frame_end_c) begin
                            state_q   <= ST_IDLE;
                            active_q  <= 1'b0;
                            bit_idx_q <= '0;
                        end else if (bit_end_c) begin
                            bit_idx_q <= bit_idx_q + IW'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_Tx_Ready  = ~fifo_full;
    assign o_Tx_Active = active_q;
    assign o_Tx_Serial = serial_q;
    assign o_Tx_Done   = done_q;
    assign o_Overflow  = ovf_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: three build configurations, directed words, frame monitors.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

    localparam int CPB = 87;
    localparam int DB [3] = '{8, 7, 5};
    localparam int PM [3] = '{1, 2, 0};
    localparam int NB [3] = '{11, 11, 7};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dv   [3];
    logic [7:0] din  [3];
    logic       ser  [3];
    logic       act  [3];
    logic       done [3];
    logic       ovf  [3];
    logic       rdy  [3];
    logic [2:0] cnt  [3];

    logic [15:0] exp_q [3][$];
    int tests = 0;
    int fails = 0;

    always #50 clk = ~clk;

    uart_tx_cfg #(.CLK_CY_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_Tx_Dv(dv[0]), .i_Tx_Byte(din[0]),
        .o_Tx_Ready(rdy[0]), .o_Tx_Active(act[0]), .o_Tx_Serial(ser[0]), .o_Tx_Done(done[0]),
        .o_Fifo_Count(cnt[0]), .o_Overflow(ovf[0]));

    uart_tx_cfg #(.CLK_CY_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_Tx_Dv(dv[1]), .i_Tx_Byte(din[1][6:0]),
        .o_Tx_Ready(rdy[1]), .o_Tx_Active(act[1]), .o_Tx_Serial(ser[1]), .o_Tx_Done(done[1]),
        .o_Fifo_Count(cnt[1]), .o_Overflow(ovf[1]));

    uart_tx_cfg #(.CLK_CY_PER_BIT(CPB), .DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_Tx_Dv(dv[2]), .i_Tx_Byte(din[2][4:0]),
        .o_Tx_Ready(rdy[2]), .o_Tx_Active(act[2]), .o_Tx_Serial(ser[2]), .o_Tx_Done(done[2]),
        .o_Fifo_Count(cnt[2]), .o_Overflow(ovf[2]));

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endfunction

    // Line image of a frame, first bit in [0]; parity value is hand-supplied per word.
    function automatic logic [15:0] mk(input int id, input logic [7:0] d, input logic p);
        logic [15:0] f = '1;
        int k = 1;
        f[0] = 1'b0;
        for (int i = 0; i < DB[id]; i++) begin
            f[k] = d[i];
            k++;
        end
        if (PM[id] != 0) f[k] = p;
        return f;
    endfunction

    task automatic drive(input int id, input logic [7:0] d, input logic p, input bit push);
        @(posedge clk); #1;
        dv[id]  = 1'b1;
        din[id] = d;
        if (push) exp_q[id].push_back(mk(id, d, p));
    endtask

    task automatic release_dv(input int id);
        @(posedge clk); #1;
        dv[id] = 1'b0;
    endtask

    task automatic wr(input int id, input logic [7:0] d, input logic p);
        drive(id, d, p, 1'b1);
        release_dv(id);
    endtask

    task automatic wait_idle(input int id);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(act[id] === 1'b0 && exp_q[id].size() == 0) && n < 8000);
        chk($sformatf("idle_timeout%0d", id), 32'(n < 8000), 1);
        chk($sformatf("idle_ready%0d", id), 32'(rdy[id]), 1);
    endtask

    task automatic run_frame(input int id, output bit next_started);
        logic [15:0] f;
        int len, bad, done_at, done_n, inact;
        bit abort;
        len = NB[id] * CPB;
        bad = 0; done_at = -1; done_n = 0; inact = 0; abort = 0;
        next_started = 0;
        chk($sformatf("frame_expected%0d", id), 32'(exp_q[id].size() != 0), 1);
        f = (exp_q[id].size() != 0) ? exp_q[id].pop_front() : 16'hFFFF;
        for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clk);
            if (!rst_n) begin
                abort = 1;
                break;
            end
            if (ser[id] !== f[c / CPB]) bad++;
            if (done[id] === 1'b1) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            if (act[id] !== 1'b1) inact++;
            if (c % CPB == CPB - 1) begin
                chk($sformatf("bit%0d_%0d", id, c / CPB), 32'(bad), 0);
                bad = 0;
            end
        end
        if (!abort) begin
            chk($sformatf("done_cycle%0d", id), 32'(done_at), 32'(len - 1));
            chk($sformatf("done_pulses%0d", id), 32'(done_n), 1);
            chk($sformatf("active_drop%0d", id), 32'(inact), 0);
            if (exp_q[id].size() != 0) begin
                @(negedge clk);
                chk($sformatf("no_gap%0d", id), {31'd0, ser[id]} | {30'd0, act[id], 1'b0}, 32'h2);
                next_started = rst_n && (ser[id] === 1'b0);
            end
        end
    endtask

    task automatic monitor(input int id);
        bit started = 0;
        forever begin
            if (!started) begin
                @(negedge clk);
                if (!(rst_n === 1'b1 && ser[id] === 1'b0)) continue;
            end
            run_frame(id, started);
        end
    endtask

    initial begin
        #(60000 * 100);
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int n, t, dt [3];
        for (int i = 0; i < 3; i++) begin
            dv[i] = 1'b0;
            din[i] = 8'h00;
        end
        rst_n = 1'b0;
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_serial%0d", i), 32'(ser[i]), 1);
            chk($sformatf("rst_ready%0d", i), 32'(rdy[i]), 1);
            chk($sformatf("rst_active%0d", i), 32'(act[i]), 0);
            chk($sformatf("rst_count%0d", i), 32'(cnt[i]), 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;

        // Single frame 0xAA, even parity 0, and first-pop latency.
        wr(0, 8'hAA, 1'b0);
        @(negedge clk);
        chk("lat_count_after_write", 32'(cnt[0]), 1);
        chk("lat_serial_before_pop", 32'(ser[0]), 1);
        @(negedge clk);
        chk("lat_serial_start", 32'(ser[0]), 0);
        chk("lat_active_start", 32'(act[0]), 1);
        chk("lat_count_after_pop", 32'(cnt[0]), 0);
        wr(1, 8'h07, 1'b0);
        wr(2, 8'h1F, 1'b0);
        wait_idle(0);
        wait_idle(1);
        wait_idle(2);

        // Odd parity of zero word is 1; no-parity 0x0A.
        wr(1, 8'h00, 1'b1);
        wr(2, 8'h0A, 1'b0);

        // Back-to-back frames with done pulses a frame apart.
        drive(0, 8'h55, 1'b0, 1'b1);
        drive(0, 8'h0F, 1'b0, 1'b1);
        drive(0, 8'hF0, 1'b0, 1'b1);
        release_dv(0);
        n = 0; t = 0;
        while (n < 3 && t < 4000) begin
            @(negedge clk);
            t++;
            if (done[0] === 1'b1) begin
                dt[n] = t;
                n++;
            end
        end
        chk("b2b_done_count", 32'(n), 3);
        if (n == 3) begin
            chk("b2b_spacing1", 32'(dt[1] - dt[0]), 957);
            chk("b2b_spacing2", 32'(dt[2] - dt[1]), 957);
        end
        wait_idle(0);
        wait_idle(1);
        wait_idle(2);

        // Six writes in six cycles: one in flight, four queued, sixth dropped.
        drive(0, 8'h01, 1'b1, 1'b1);
        drive(0, 8'h03, 1'b0, 1'b1);
        drive(0, 8'h07, 1'b1, 1'b1);
        drive(0, 8'h80, 1'b1, 1'b1);
        drive(0, 8'hFE, 1'b1, 1'b1);
        drive(0, 8'h99, 1'b0, 1'b0);
        release_dv(0);
        @(negedge clk);
        chk("ovf_pulse", 32'(ovf[0]), 1);
        chk("ovf_ready_low", 32'(rdy[0]), 0);
        chk("ovf_count_full", 32'(cnt[0]), 4);
        @(negedge clk);
        chk("ovf_one_cycle", 32'(ovf[0]), 0);
        chk("ovf_count_kept", 32'(cnt[0]), 4);
        wait_idle(0);

        // Reset in the middle of the data phase.
        wr(0, 8'h3C, 1'b0);
        n = 0;
        while (ser[0] !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (CPB * 3) @(negedge clk);
        chk("mid_in_data", 32'(act[0]), 1);
        #10 rst_n = 1'b0;
        #1;
        chk("mid_rst_serial", 32'(ser[0]), 1);
        chk("mid_rst_active", 32'(act[0]), 0);
        chk("mid_rst_ready", 32'(rdy[0]), 1);
        chk("mid_rst_count", 32'(cnt[0]), 0);
        chk("mid_rst_done", 32'(done[0]), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (ser[0] !== 1'b1 || act[0] !== 1'b0) n++;
        end
        chk("no_resume_after_reset", 32'(n), 0);
        wr(0, 8'hC3, 1'b0);
        wait_idle(0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
